// File: rtl/ae350_reset_seq_if.sv
// Signal bundle between the reset sequencer and its surroundings: lock/init status
// and software request in, the three SoC reset lines and sequencer status out.
interface ae350_reset_seq_if;
    logic       pll_lock_i;
    logic       ddr3_lock_i;
    logic       ddr3_init_i;
    logic       sw_rst_req_i;
    logic       ddr3_rstn_o;
    logic       por_rstn_o;
    logic       hw_rstn_o;
    logic [2:0] state_o;
    logic [2:0] retry_cnt_o;
    logic       fail_o;

    modport master (
        output pll_lock_i, ddr3_lock_i, ddr3_init_i, sw_rst_req_i,
        input  ddr3_rstn_o, por_rstn_o, hw_rstn_o, state_o, retry_cnt_o, fail_o
    );

    modport slave (
        input  pll_lock_i, ddr3_lock_i, ddr3_init_i, sw_rst_req_i,
        output ddr3_rstn_o, por_rstn_o, hw_rstn_o, state_o, retry_cnt_o, fail_o
    );
endinterface

// File: rtl/ae350_reset_seq.sv
// AE350 reset sequencer: waits for stable PLL locks, runs DDR3 init with retries,
// then releases POR and HW resets in order; supports a software HW-reset pulse.
module ae350_reset_seq #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned DDR_RST_CYCLES     = 256,
    parameter int unsigned INIT_TIMEOUT       = 5000000,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned POR_TO_HW_CYCLES   = 64,
    parameter int unsigned HW_PULSE_CYCLES    = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    ae350_reset_seq_if.slave  bus
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned RTY_W = 3;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DDR_LAST   = CNT_W'(DDR_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_TO_HW_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(HW_PULSE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_DDR_RST   = 3'd1,
        ST_WAIT_INIT = 3'd2,
        ST_POR_REL   = 3'd3,
        ST_RUN       = 3'd4,
        ST_HW_PULSE  = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
    logic [1:0]       pll_sync, ddr_sync, init_sync;
    logic             lock_s, init_s;
    logic             ddr3_rstn_q, por_rstn_q, hw_rstn_q, fail_q;

    // Two-flop synchronisers for the asynchronous status inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pll_sync  <= '0;
            ddr_sync  <= '0;
            init_sync <= '0;
        end else begin
            pll_sync  <= {pll_sync[0],  bus.pll_lock_i};
            ddr_sync  <= {ddr_sync[0],  bus.ddr3_lock_i};
            init_sync <= {init_sync[0], bus.ddr3_init_i};
        end
    end

    assign lock_s    = pll_sync[1] & ddr_sync[1];
    assign init_s    = init_sync[1];
    assign retry_inc = retry_q + RTY_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            retry_q     <= '0;
            ddr3_rstn_q <= 1'b0;
            por_rstn_q  <= 1'b0;
            hw_rstn_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            ddr3_rstn_q <= state_d inside {ST_WAIT_INIT, ST_POR_REL, ST_RUN, ST_HW_PULSE};
            por_rstn_q  <= state_d inside {ST_POR_REL, ST_RUN, ST_HW_PULSE};
            hw_rstn_q   <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    // Next state; lock loss (and init loss once released) override every active state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;

        if (state_q != ST_WAIT_LOCK && state_q != ST_FAIL &&
            (!lock_s ||
             (!init_s && state_q inside {ST_POR_REL, ST_RUN, ST_HW_PULSE}))) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = ST_DDR_RST;
                        cnt_d   = '0;
                    end
                end
                ST_DDR_RST: begin
                    if (cnt_q == DDR_LAST) begin
                        state_d = ST_WAIT_INIT;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_INIT: begin
                    if (init_s) begin
                        state_d = ST_POR_REL;
                        cnt_d   = '0;
                    end else if (cnt_q == INIT_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RTY_MAX) ? ST_FAIL : ST_DDR_RST;
                        cnt_d   = '0;
                    end
                end
                ST_POR_REL: begin
                    if (cnt_q == POR_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                    if (bus.sw_rst_req_i) state_d = ST_HW_PULSE;
                end
                ST_HW_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_FAIL: cnt_d = '0;
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    assign bus.ddr3_rstn_o = ddr3_rstn_q;
    assign bus.por_rstn_o  = por_rstn_q;
    assign bus.hw_rstn_o   = hw_rstn_q;
    assign bus.fail_o      = fail_q;
    assign bus.state_o     = state_q;
    assign bus.retry_cnt_o = retry_q;

endmodule
